// File: rtl/imem_program_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words, writes
// them into instruction memory and holds the CPU in reset until the EOF word lands.
module imem_program_loader #(
  parameter int          DEPTH    = 35,
  parameter int          ADDR_W   = 6,
  parameter logic [31:0] EOF_WORD = 32'hFFFF_FFFF
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              imem_wr_en,
  output logic [ADDR_W-1:0] imem_index,
  output logic [31:0]       imem_entry,
  output logic              cpu_rst,
  output logic              loaded,
  output logic [ADDR_W:0]   word_count,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERR} state_t;

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t      state, next_state;
  logic [1:0]  byte_idx;
  logic [31:0] assembler;
  logic [31:0] word_next;
  logic        eof_pending;
  logic        handshake;
  logic        word_done;
  logic        start_load;
  logic        mem_full;

  // State register plus registered outputs, derived from next_state so they
  // change on the same edge as the state itself.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state       <= IDLE;
      byte_idx    <= 2'd0;
      assembler   <= 32'd0;
      eof_pending <= 1'b0;
      imem_wr_en  <= 1'b0;
      imem_index  <= '0;
      imem_entry  <= 32'd0;
      word_count  <= '0;
      cpu_rst     <= 1'b1;
      loaded      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state       <= next_state;
      cpu_rst     <= (next_state != RUN);
      loaded      <= (next_state == RUN);
      overflow    <= (next_state == ERR);
      imem_wr_en  <= 1'b0;
      eof_pending <= 1'b0;
      if (start_load) begin
        byte_idx   <= 2'd0;
        assembler  <= 32'd0;
        word_count <= '0;
      end else begin
        if (imem_wr_en)
          word_count <= word_count + 1'b1;
        if (handshake) begin
          byte_idx  <= byte_idx + 2'd1;
          assembler <= word_next;
        end
        // A completed word can never coincide with a write pulse, so word_count is current here.
        if (word_done && !mem_full) begin
          imem_wr_en  <= 1'b1;
          imem_index  <= word_count[ADDR_W-1:0];
          imem_entry  <= word_next;
          eof_pending <= (word_next == EOF_WORD);
        end
      end
    end
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves next_state unassigned (no latch).
    next_state = state;
    case (state)
      IDLE, RUN, ERR: if (start) next_state = LOAD;
      LOAD: begin
        if (eof_pending)
          next_state = RUN;
        else if (word_done && mem_full)
          next_state = ERR;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == LOAD) && !eof_pending;
    handshake  = in_valid && in_ready;
    word_done  = handshake && (byte_idx == 2'd3);
    word_next  = {in_data, assembler[31:8]};
    start_load = start && (state != LOAD);
    mem_full   = (word_count == DEPTH_W);
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed bench for imem_program_loader: streams hand-built programs and compares
// every write, status output and boundary case against precomputed values.
module tb_imem_program_loader;

  localparam int          DEPTH  = 35;
  localparam int          ADDR_W = 6;
  localparam logic [31:0] EOFW   = 32'hFFFF_FFFF;

  logic              CLOCK_50 = 1'b0;
  logic              rst      = 1'b1;
  logic              start    = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_data  = 8'h00;
  logic              in_ready;
  logic              imem_wr_en;
  logic [ADDR_W-1:0] imem_index;
  logic [31:0]       imem_entry;
  logic              cpu_rst;
  logic              loaded;
  logic [ADDR_W:0]   word_count;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  imem_program_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .EOF_WORD(EOFW)) dut (
    .CLOCK_50  (CLOCK_50),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .imem_wr_en(imem_wr_en),
    .imem_index(imem_index),
    .imem_entry(imem_entry),
    .cpu_rst   (cpu_rst),
    .loaded    (loaded),
    .word_count(word_count),
    .overflow  (overflow)
  );

  // Write log, owned solely by this monitor; sampled on the falling edge.
  logic [ADDR_W-1:0] log_idx [0:255];
  logic [31:0]       log_ent [0:255];
  logic              log_rdy [0:255];
  int                wr_total = 0;

  always @(negedge CLOCK_50) begin
    if (imem_wr_en && wr_total < 256) begin
      log_idx[wr_total] = imem_index;
      log_ent[wr_total] = imem_entry;
      log_rdy[wr_total] = in_ready;
      wr_total++;
    end
  end

  int          base = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_50);
  endtask

  task automatic apply_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (2) tick();
    rst = 1'b0;
    base = wr_total;
    exp_q.delete();
  endtask

  task automatic pulse_start();
    base = wr_total;
    exp_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("byte_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    in_data  = 8'h5A;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int i = 0; i < 4; i++)
      send_byte(w[8*i +: 8], gap);
    exp_q.push_back(w);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_count"}, 64'(wr_total - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && base + i < wr_total; i++) begin
      check($sformatf("%s_idx%0d", tag, i), 64'(log_idx[base+i]), 64'(i));
      check($sformatf("%s_ent%0d", tag, i), 64'(log_ent[base+i]), 64'(exp_q[i]));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Reset values
    apply_reset();
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_wr_en", imem_wr_en, 0);
    check("rst_index", imem_index, 0);
    check("rst_entry", imem_entry, 0);
    check("rst_loaded", loaded, 0);
    check("rst_word_count", word_count, 0);
    check("rst_overflow", overflow, 0);

    // 1: back-to-back stream, exact pulse timing
    pulse_start();
    check("t1_ready_after_start", in_ready, 1);
    send_word(32'h0050_0013, 0);
    send_word(EOFW, 0);
    check("t1_eof_pulse", imem_wr_en, 1);
    check("t1_eof_index", imem_index, 1);
    check("t1_eof_entry", imem_entry, EOFW);
    check("t1_eof_ready", in_ready, 0);
    check("t1_eof_cpu_rst", cpu_rst, 1);
    tick();
    check("t1_cpu_rst_low", cpu_rst, 0);
    check("t1_loaded", loaded, 1);
    check("t1_word_count", word_count, 2);
    check("t1_wr_en_low", imem_wr_en, 0);
    check_writes("t1");

    // 2: throttled stream from RUN, also covers restart from RUN
    pulse_start();
    check("t2_cpu_rst", cpu_rst, 1);
    check("t2_loaded", loaded, 0);
    check("t2_word_count", word_count, 0);
    send_byte(8'h13, 1);
    send_byte(8'h00, 1);
    send_byte(8'h50, 1);
    check("t2_no_early_write", 64'(wr_total - base), 0);
    send_byte(8'h00, 1);
    exp_q.push_back(32'h0050_0013);
    send_word(EOFW, 1);
    tick();
    check_writes("t2");
    if (wr_total - base == 2)
      check("t2_eof_pulse_ready", log_rdy[base+1], 0);
    check("t2_loaded", loaded, 1);
    check("t2_word_count_end", word_count, 2);

    // 3a: program that exactly fills memory
    pulse_start();
    for (int i = 0; i < DEPTH - 1; i++)
      send_word(32'h1000_0000 + 32'(i) * 32'h0001_0101, 0);
    send_word(EOFW, 0);
    repeat (2) tick();
    check_writes("t3a");
    check("t3a_loaded", loaded, 1);
    check("t3a_cpu_rst", cpu_rst, 0);
    check("t3a_word_count", word_count, DEPTH);
    check("t3a_overflow", overflow, 0);

    // 3b: one word too many, EOF must not be written
    pulse_start();
    for (int i = 0; i < DEPTH; i++)
      send_word(32'h2000_0000 + 32'(i) * 32'h0000_0707, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    send_byte(8'hFF, 0);
    repeat (2) tick();
    check_writes("t3b");
    check("t3b_overflow", overflow, 1);
    check("t3b_cpu_rst", cpu_rst, 1);
    check("t3b_loaded", loaded, 0);
    check("t3b_word_count", word_count, DEPTH);
    check("t3b_in_ready", in_ready, 0);

    // 4: reset in the middle of word 3, then a clean reload
    pulse_start();
    check("t4_overflow_cleared", overflow, 0);
    send_word(32'hAAAA_0001, 0);
    send_word(32'hAAAA_0002, 0);
    send_byte(8'hC1, 0);
    send_byte(8'hC2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_in_ready", in_ready, 0);
    check("t4_word_count", word_count, 0);
    check("t4_cpu_rst", cpu_rst, 1);
    check("t4_loaded", loaded, 0);
    pulse_start();
    send_word(32'h1234_5678, 0);
    send_word(EOFW, 0);
    tick();
    check_writes("t4");
    check("t4_loaded_end", loaded, 1);

    // 5: restart from RUN with a 3-word program
    pulse_start();
    check("t5_cpu_rst", cpu_rst, 1);
    check("t5_loaded", loaded, 0);
    check("t5_word_count", word_count, 0);
    send_word(32'h0000_0093, 0);
    send_word(32'h00A0_0113, 0);
    send_word(EOFW, 0);
    tick();
    check_writes("t5");
    check("t5_loaded_end", loaded, 1);
    check("t5_word_count_end", word_count, 3);

    // 6: in_valid in IDLE and start mid-load are both ignored
    apply_reset();
    in_valid = 1'b1;
    in_data  = 8'h77;
    repeat (3) tick();
    check("t6_idle_ready", in_ready, 0);
    check("t6_idle_writes", 64'(wr_total - base), 0);
    check("t6_idle_cpu_rst", cpu_rst, 1);
    check("t6_idle_word_count", word_count, 0);
    in_valid = 1'b0;
    pulse_start();
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t6_still_loading", in_ready, 1);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    exp_q.push_back(32'h4433_2211);
    send_word(EOFW, 0);
    tick();
    check_writes("t6");
    check("t6_word_count", word_count, 2);
    check("t6_loaded", loaded, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
